// File: rtl/hack_alu_seq.sv
// Registered Hack ALU with start/done handshake.
// Adds a W-cycle shift-add multiply and a carry-out flag.
module hack_alu_seq #(
  parameter int W  = 16,
  parameter int CW = $clog2(W+1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         zx,
  input  logic         nx,
  input  logic         zy,
  input  logic         ny,
  input  logic         f,
  input  logic         no,
  input  logic         mul,
  output logic [W-1:0] out,
  output logic         zr,
  output logic         ng,
  output logic         cy,
  output logic         busy,
  output logic         done
);

  typedef enum logic {
    IDLE,
    MUL
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  out_q, out_d;
  logic          zr_q, zr_d;
  logic          ng_q, ng_d;
  logic          cy_q, cy_d;
  logic          done_q, done_d;

  logic [W-1:0]  xz, xs, yz, ys;
  logic [W:0]    sum;
  logic [W-1:0]  fr, res;
  logic [W-1:0]  acc_nx;
  logic          last;

  // Hack function: operand conditioning, add/and, output inversion
  always_comb begin
    xz  = zx ? '0 : x;
    xs  = nx ? ~xz : xz;
    yz  = zy ? '0 : y;
    ys  = ny ? ~yz : yz;
    sum = {1'b0, xs} + {1'b0, ys};
    fr  = f ? sum[W-1:0] : (xs & ys);
    res = no ? ~fr : fr;
  end

  // One shift-add step; last step is the W-th iteration
  always_comb begin
    acc_nx = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    last   = (cnt_q == CW'(W - 1));
  end

  // Next state, datapath updates and the done pulse
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    zr_d     = zr_q;
    ng_d     = ng_q;
    cy_d     = cy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (mul) begin
            mcand_d  = x;
            mplier_d = y;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            out_d  = res;
            zr_d   = (res == '0);
            ng_d   = res[W-1];
            cy_d   = f & sum[W];
            done_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          out_d   = acc_nx;
          zr_d    = (acc_nx == '0);
          ng_d    = acc_nx[W-1];
          cy_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      zr_q     <= 1'b1;
      ng_q     <= 1'b0;
      cy_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      zr_q     <= zr_d;
      ng_q     <= ng_d;
      cy_q     <= cy_d;
      done_q   <= done_d;
    end
  end

  assign out  = out_q;
  assign zr   = zr_q;
  assign ng   = ng_q;
  assign cy   = cy_q;
  assign done = done_q;
  assign busy = (state_q == MUL);

endmodule

// File: tb/tb_hack_alu_seq.sv
// Bench for hack_alu_seq: cycle model plus directed
// literal checks, W=16 main instance, W=8/W=32 sweep.
module tb_hack_alu_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mul   = 1'b0;
  logic [15:0] x     = '0;
  logic [15:0] y     = '0;
  logic [5:0]  ctl   = '0;
  logic [15:0] out;
  logic        zr, ng, cy, busy, done;

  logic        start8 = 1'b0;
  logic [7:0]  x8 = '0, y8 = '0, out8;
  logic        zr8, ng8, cy8, busy8, done8;

  logic        start32 = 1'b0;
  logic [31:0] x32 = '0, y32 = '0, out32;
  logic        zr32, ng32, cy32, busy32, done32;

  logic        tie0 = 1'b0;
  logic        tie1 = 1'b1;

  int total = 0;
  int bad   = 0;
  bit chk   = 1'b0;

  always #5 clock = ~clock;

  hack_alu_seq #(.W(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .x(x), .y(y),
    .zx(ctl[5]), .nx(ctl[4]), .zy(ctl[3]),
    .ny(ctl[2]), .f(ctl[1]), .no(ctl[0]),
    .mul(mul), .out(out), .zr(zr), .ng(ng),
    .cy(cy), .busy(busy), .done(done)
  );

  hack_alu_seq #(.W(8)) u8 (
    .clock(clock), .reset(reset), .start(start8),
    .x(x8), .y(y8),
    .zx(tie0), .nx(tie0), .zy(tie0),
    .ny(tie0), .f(tie0), .no(tie0),
    .mul(tie1), .out(out8), .zr(zr8), .ng(ng8),
    .cy(cy8), .busy(busy8), .done(done8)
  );

  hack_alu_seq #(.W(32)) u32 (
    .clock(clock), .reset(reset), .start(start32),
    .x(x32), .y(y32),
    .zx(tie0), .nx(tie0), .zy(tie0),
    .ny(tie0), .f(tie0), .no(tie0),
    .mul(tie1), .out(out32), .zr(zr32), .ng(ng32),
    .cy(cy32), .busy(busy32), .done(done32)
  );

  task automatic check(input string nm,
                       input logic [31:0] a,
                       input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, a, e, $time);
    end
  endtask

  // Spec-level Hack function: returns {cy, result}
  function automatic logic [16:0] hack(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [5:0]  c
  );
    logic [15:0] xa, yb, r;
    logic [16:0] s;
    xa = c[5] ? 16'h0 : a;
    if (c[4]) xa = ~xa;
    yb = c[3] ? 16'h0 : b;
    if (c[2]) yb = ~yb;
    s = {1'b0, xa} + {1'b0, yb};
    r = c[1] ? s[15:0] : (xa & yb);
    if (c[0]) r = ~r;
    return {c[1] & s[16], r};
  endfunction

  logic [15:0] e_out = '0;
  logic [15:0] pend  = '0;
  logic [16:0] hv;
  bit e_zr = 1'b1, e_ng = 1'b0, e_cy = 1'b0;
  bit e_busy = 1'b0, e_done = 1'b0;
  int rem = 0;

  // Cycle model: a multiply finishes 16 edges after accept
  always @(posedge clock) begin
    if (reset) begin
      e_out = '0; e_zr = 1; e_ng = 0; e_cy = 0;
      e_busy = 0; e_done = 0; rem = 0;
    end else if (e_busy) begin
      e_done = 0;
      rem--;
      if (rem == 0) begin
        e_busy = 0; e_done = 1;
        e_out = pend; e_zr = (pend == 0);
        e_ng = pend[15]; e_cy = 0;
      end
    end else if (start && mul) begin
      e_busy = 1; e_done = 0; rem = 16;
      pend = x * y;
    end else if (start) begin
      hv = hack(x, y, ctl);
      e_out = hv[15:0]; e_zr = (hv[15:0] == 0);
      e_ng = hv[15]; e_cy = hv[16]; e_done = 1;
    end else begin
      e_done = 0;
    end
  end

  // Compare every cycle once reset has been applied
  always @(negedge clock) begin
    if (chk) begin
      check("m_out",  32'(out),  32'(e_out));
      check("m_zr",   32'(zr),   32'(e_zr));
      check("m_ng",   32'(ng),   32'(e_ng));
      check("m_cy",   32'(cy),   32'(e_cy));
      check("m_busy", 32'(busy), 32'(e_busy));
      check("m_done", 32'(done), 32'(e_done));
    end
  end

  task automatic do_mul(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic [15:0] want,
                        input string nm);
    int n, nb;
    @(negedge clock);
    x = a; y = b; mul = 1; start = 1;
    @(negedge clock);
    start = 0; x = 16'h5A5A; y = 16'hA5A5;
    n = 0; nb = busy ? 1 : 0;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
      if (busy) nb++;
    end
    check({nm, "_lat"},  32'(n),  32'd16);
    check({nm, "_busy"}, 32'(nb), 32'd16);
    check({nm, "_out"},  32'(out), 32'(want));
  endtask

  logic [5:0] ops[5] = '{6'b000010, 6'b010011,
                         6'b000000, 6'b101010, 6'b111010};
  logic [15:0] ev[5] = '{16'd24, 16'hFFFA, 16'd9,
                         16'd0, 16'hFFFF};

  initial begin
    int n, nd;
    repeat (2) @(negedge clock);
    chk = 1;
    check("rst_out",  32'(out),  32'd0);
    check("rst_zr",   32'(zr),   32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 0;

    // Hack set, start held high
    x = 16'd9; y = 16'd15; mul = 0; start = 1;
    for (int i = 0; i < 5; i++) begin
      ctl = ops[i];
      @(negedge clock);
      check("hack_out",  32'(out),  32'(ev[i]));
      check("hack_done", 32'(done), 32'd1);
    end
    check("hack_ng", 32'(ng), 32'd1);
    start = 0;
    @(negedge clock);

    // Carry
    x = 16'hFFFF; y = 16'd1; ctl = 6'b000010; start = 1;
    @(negedge clock);
    start = 0;
    check("cy_done", 32'(done), 32'd1);
    check("cy_out",  32'(out),  32'd0);
    check("cy_zr",   32'(zr),   32'd1);
    check("cy_cy",   32'(cy),   32'd1);

    // Reset during multiply at cnt=5
    @(negedge clock);
    x = 16'd9; y = 16'd15; mul = 1; start = 1;
    @(negedge clock);
    start = 0;
    repeat (5) @(negedge clock);
    reset = 1;
    repeat (2) @(negedge clock);
    check("rmul_out",  32'(out),  32'd0);
    check("rmul_zr",   32'(zr),   32'd1);
    check("rmul_cy",   32'(cy),   32'd0);
    check("rmul_busy", 32'(busy), 32'd0);
    reset = 0;
    nd = 0;
    repeat (20) begin
      @(negedge clock);
      if (done) nd++;
    end
    check("rmul_nodone", 32'(nd), 32'd0);

    do_mul(16'd9, 16'd15, 16'd135, "mul_9x15");
    do_mul(16'hFFFD, 16'd7, 16'hFFEB, "mul_m3x7");
    check("mul_m3x7_ng", 32'(ng), 32'd1);
    do_mul(16'd300, 16'd300, 16'd24464, "mul_300");

    // start with mul=0 during a multiply is dropped
    @(negedge clock);
    x = 16'd9; y = 16'd15; mul = 1; start = 1;
    @(negedge clock);
    start = 0;
    repeat (2) @(negedge clock);
    mul = 0; ctl = 6'b000010; x = 16'd1; y = 16'd1;
    start = 1;
    @(negedge clock);
    start = 0;
    nd = 0;
    repeat (30) begin
      @(negedge clock);
      if (done) nd++;
    end
    check("hs_ndone", 32'(nd),  32'd1);
    check("hs_out",   32'(out), 32'd135);

    // W=8 sweep
    x8 = 8'd200; y8 = 8'd3; start8 = 1;
    @(negedge clock);
    start8 = 0;
    n = 0;
    while (!done8 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("w8_lat", 32'(n),    32'd8);
    check("w8_out", 32'(out8), 32'd88);

    // W=32 sweep
    x32 = 32'd65536; y32 = 32'd65536; start32 = 1;
    @(negedge clock);
    start32 = 0;
    n = 0;
    while (!done32 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("w32_lat", 32'(n),    32'd32);
    check("w32_out", out32,     32'd0);
    check("w32_zr",  32'(zr32), 32'd1);

    @(negedge clock);
    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
